// File: rtl/rx_dir_arbiter_pkg.sv
// Shared definitions for the receive-direction arbiter: link direction codes,
// FSM state encoding and the AXI-Stream keep-width helper.
package rx_dir_arbiter_pkg;

    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_W = 2'd2;
    localparam logic [1:0] DIR_N = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } arb_state_t;

    function automatic int axis_keep_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rx_dir_arbiter_req_sync.sv
// Multi-flop synchroniser for one asynchronous two-phase request line.
// Works for any depth >= 1; the output is the last flop of the chain.
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the previous stage's old value.
            sync_q <= (sync_q << 1) | STAGES'(d);
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rx_dir_arbiter.sv
// Round-robin arbiter forwarding one two-phase REQ/ACK link (E/S/W/N) at a time
// onto an AXI-Stream master, framing packets by word count or idle timeout.
module rx_dir_arbiter
    import rx_dir_arbiter_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int MAX_BURST    = 256,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_en,
    input  logic                        E_RX_REQ,
    input  logic [DATA_W-1:0]           E_RX_DATA,
    output logic                        E_RX_ACK,
    input  logic                        S_RX_REQ,
    input  logic [DATA_W-1:0]           S_RX_DATA,
    output logic                        S_RX_ACK,
    input  logic                        W_RX_REQ,
    input  logic [DATA_W-1:0]           W_RX_DATA,
    output logic                        W_RX_ACK,
    input  logic                        N_RX_REQ,
    input  logic [DATA_W-1:0]           N_RX_DATA,
    output logic                        N_RX_ACK,
    output logic [DATA_W-1:0]           M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic [axis_keep_w(DATA_W)-1:0] M_AXIS_TKEEP,
    output logic                        M_AXIS_TLAST,
    output logic                        RECE_DONE,
    output logic [31:0]                 RECE_COUNT,
    output logic [1:0]                  Receive_Direction,
    output logic                        busy
);

    localparam int KEEP_W = axis_keep_w(DATA_W);
    localparam int WCNT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t        state, state_nxt;
    logic [3:0]        req_raw, req_s, ack, pending;
    logic [DATA_W-1:0] link_data [4];
    logic [1:0]        grant, rr_ptr, arb_dir, cand;
    logic              arb_found, do_grant, take, flush, out_free;
    logic [DATA_W-1:0] h_data, out_data;
    logic              hv, out_valid, out_last, rece_done;
    logic [WCNT_W-1:0] word_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [31:0]       rece_count;

    assign req_raw = {N_RX_REQ, W_RX_REQ, S_RX_REQ, E_RX_REQ};
    assign link_data[DIR_E] = E_RX_DATA;
    assign link_data[DIR_S] = S_RX_DATA;
    assign link_data[DIR_W] = W_RX_DATA;
    assign link_data[DIR_N] = N_RX_DATA;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        req_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_raw[i]),
            .q     (req_s[i])
        );
    end

    assign pending  = req_s ^ ack;
    assign out_free = !out_valid || M_AXIS_TREADY;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        state_nxt = state;
        do_grant  = 1'b0;
        take      = 1'b0;
        flush     = 1'b0;
        arb_found = 1'b0;
        arb_dir   = rr_ptr;
        cand      = rr_ptr;

        // Search starts just after the last winner; i=4 wraps back to the pointer itself.
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!arb_found && pending[cand]) begin
                arb_found = 1'b1;
                arb_dir   = cand;
            end
        end

        case (state)
            ST_IDLE: begin
                if (rx_en && arb_found) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (word_cnt == WCNT_W'(MAX_BURST)) begin
                    if (out_free) begin
                        flush     = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end else if (pending[grant] && (!hv || out_free)) begin
                    take = 1'b1;
                end else if (hv && idle_cnt == IDLE_W'(IDLE_TIMEOUT) && out_free) begin
                    flush     = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && M_AXIS_TREADY && out_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= DIR_N;
            grant      <= DIR_E;
            ack        <= '0;
            // NOTE: the data registers are reset too because TDATA must read zero out of reset.
            h_data     <= '0;
            hv         <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            rece_count <= '0;
            rece_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rece_done <= out_valid && M_AXIS_TREADY && out_last;
            if (out_valid && M_AXIS_TREADY) rece_count <= rece_count + 32'd1;

            if (do_grant) begin
                grant    <= arb_dir;
                rr_ptr   <= arb_dir;
                word_cnt <= '0;
                idle_cnt <= '0;
            end

            if (take) begin
                h_data       <= link_data[grant];
                hv           <= 1'b1;
                ack[grant]   <= ~ack[grant];
                word_cnt     <= word_cnt + WCNT_W'(1);
                idle_cnt     <= '0;
            end else if (state == ST_COLLECT && idle_cnt != IDLE_W'(IDLE_TIMEOUT)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (flush) hv <= 1'b0;

            // H feeds the output slot: on a new word (TLAST=0) or when the packet closes (TLAST=1).
            if ((take && hv) || flush) begin
                out_valid <= 1'b1;
                out_data  <= h_data;
                out_last  <= flush;
            end else if (out_valid && M_AXIS_TREADY) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign {N_RX_ACK, W_RX_ACK, S_RX_ACK, E_RX_ACK} = ack;
    assign M_AXIS_TDATA      = out_data;
    assign M_AXIS_TVALID     = out_valid;
    assign M_AXIS_TLAST      = out_last;
    assign M_AXIS_TKEEP      = {KEEP_W{out_valid}};
    assign RECE_DONE         = rece_done;
    assign RECE_COUNT        = rece_count;
    assign Receive_Direction = grant;
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_dir_arbiter.sv
// Scoreboard bench for rx_dir_arbiter: two-phase link senders feed the DUT,
// expected beats are queued as words are issued and checked as they leave M_AXIS.
module tb_rx_dir_arbiter;

    localparam int DATA_W   = 16;
    localparam int MAX_B    = 256;
    localparam int IDLE_TO  = 40;

    typedef struct packed {
        logic [1:0]  dir;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_en;
    logic        tready;
    logic        link_clr;
    logic [3:0]  ack_vec;
    logic        E_RX_ACK, S_RX_ACK, W_RX_ACK, N_RX_ACK;
    logic [15:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID, M_AXIS_TLAST, RECE_DONE, busy;
    logic [1:0]  M_AXIS_TKEEP;
    logic [31:0] RECE_COUNT;
    logic [1:0]  Receive_Direction;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    exp_count   = 0;

    always #5 clk = ~clk;

    assign ack_vec = {N_RX_ACK, W_RX_ACK, S_RX_ACK, E_RX_ACK};

    // One two-phase sender per link: a new word goes out only once the previous one is acked.
    for (genvar d = 0; d < 4; d++) begin : g_link
        logic        req;
        logic [15:0] data;
        logic [15:0] q[$];
        initial begin
            req  = 1'b0;
            data = '0;
            forever begin
                @(negedge clk);
                if (link_clr) begin
                    req  = 1'b0;
                    data = '0;
                    q.delete();
                end else if (q.size() != 0 && req == ack_vec[d]) begin
                    data = q.pop_front();
                    req  = ~req;
                end
            end
        end
    end

    rx_dir_arbiter #(
        .DATA_W(DATA_W), .SYNC_STAGES(2), .MAX_BURST(MAX_B), .IDLE_TIMEOUT(IDLE_TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_en             (rx_en),
        .E_RX_REQ          (g_link[0].req),
        .E_RX_DATA         (g_link[0].data),
        .E_RX_ACK          (E_RX_ACK),
        .S_RX_REQ          (g_link[1].req),
        .S_RX_DATA         (g_link[1].data),
        .S_RX_ACK          (S_RX_ACK),
        .W_RX_REQ          (g_link[2].req),
        .W_RX_DATA         (g_link[2].data),
        .W_RX_ACK          (W_RX_ACK),
        .N_RX_REQ          (g_link[3].req),
        .N_RX_DATA         (g_link[3].data),
        .N_RX_ACK          (N_RX_ACK),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TREADY     (tready),
        .M_AXIS_TKEEP      (M_AXIS_TKEEP),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .RECE_DONE         (RECE_DONE),
        .RECE_COUNT        (RECE_COUNT),
        .Receive_Direction (Receive_Direction),
        .busy              (busy)
    );

    task automatic push_link(input int d, input logic [15:0] w);
        case (d)
            0: g_link[0].q.push_back(w);
            1: g_link[1].q.push_back(w);
            2: g_link[2].q.push_back(w);
            default: g_link[3].q.push_back(w);
        endcase
    endtask

    task automatic push_word(input int d, input logic [15:0] w, input logic last);
        sb.push_back(beat_t'{dir: 2'(d), data: w, last: last});
        exp_count++;
        push_link(d, w);
    endtask

    // Drives TREADY (with an optional stall), pops the scoreboard on every accepted beat.
    task automatic collect(input int n, input int budget, input int stall_at,
                           input int stall_len, output int dones);
        int          got, cyc, stall, tail;
        logic [15:0] hold_d;
        logic        hold_l, hold_set, stable;
        logic [3:0]  ack_snap;
        beat_t       e;
        got = 0; cyc = 0; stall = 0; tail = 0; dones = 0;
        hold_d = '0; hold_l = 1'b0; hold_set = 1'b0; stable = 1'b1; ack_snap = '0;
        while (tail < 4) begin
            @(negedge clk);
            cyc++;
            if (RECE_DONE) dones++;
            if (cyc > budget) begin
                vectors++; miscompares++;
                $display("FAIL collect_timeout: %0d beats seen, %0d required", got, n);
                break;
            end
            if (stall_len > 0 && got == stall_at && stall < stall_len) begin
                tready = 1'b0;
                stall++;
                if (stall == 10) ack_snap = ack_vec;
                if (M_AXIS_TVALID) begin
                    if (!hold_set) begin
                        hold_d = M_AXIS_TDATA; hold_l = M_AXIS_TLAST; hold_set = 1'b1;
                    end else if (M_AXIS_TDATA !== hold_d || M_AXIS_TLAST !== hold_l) begin
                        stable = 1'b0;
                    end
                end
                if (stall == stall_len) begin
                    vectors++;
                    if (!(stable && hold_set)) begin
                        miscompares++;
                        $display("FAIL stall_hold: valid_seen=%0b stable=%0b, required 1/1", hold_set, stable);
                    end
                    vectors++;
                    if (ack_vec !== ack_snap) begin
                        miscompares++;
                        $display("FAIL stall_ack: acks %b, required unchanged %b", ack_vec, ack_snap);
                    end
                end
            end else begin
                tready = 1'b1;
            end
            if (M_AXIS_TVALID && tready) begin
                vectors++;
                if (got >= n || sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: data %h dir %0d, required no beat", M_AXIS_TDATA, Receive_Direction);
                end else begin
                    e = sb.pop_front();
                    if (M_AXIS_TDATA !== e.data || M_AXIS_TLAST !== e.last ||
                        Receive_Direction !== e.dir || M_AXIS_TKEEP !== 2'b11) begin
                        miscompares++;
                        $display("FAIL beat%0d: data %h last %b dir %0d keep %b, required data %h last %b dir %0d keep 11",
                                 got, M_AXIS_TDATA, M_AXIS_TLAST, Receive_Direction, M_AXIS_TKEEP,
                                 e.data, e.last, e.dir);
                    end
                end
                got++;
            end
            if (got >= n) tail++;
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_en = 1'b1; tready = 1'b1; link_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP, RECE_DONE, RECE_COUNT,
             Receive_Direction, busy, ack_vec} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: tvalid %b tlast %b tdata %h tkeep %b done %b count %0d dir %0d busy %b acks %b, required all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP, RECE_DONE, RECE_COUNT,
                     Receive_Direction, busy, ack_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rr_order();
        int dones;
        logic [15:0] base [4];
        base[0] = 16'hE000; base[1] = 16'h5000; base[2] = 16'hA000; base[3] = 16'h9000;
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) push_word(d, base[d] + 16'(i), i == 2);
        collect(12, 1500, -1, 0, dones);
        vectors++;
        if (dones !== 4) begin
            miscompares++;
            $display("FAIL rr_done_count: %0d, required 4", dones);
        end
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL rr_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        for (int i = 1; i <= 5; i++) push_word(2, 16'(i), i == 5);
        collect(5, 600, -1, 0, dones);
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL b2b_done_count: %0d, required 1", dones);
        end
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL b2b_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    task automatic test_max_burst();
        int dones;
        for (int i = 0; i < 300; i++) push_word(2, 16'h1000 + 16'(i), (i == MAX_B - 1) || (i == 299));
        collect(300, 4000, -1, 0, dones);
        vectors++;
        if (dones !== 2) begin
            miscompares++;
            $display("FAIL burst_done_count: %0d, required 2", dones);
        end
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL burst_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int dones;
        for (int i = 0; i < 20; i++) push_word(0, 16'hC000 + 16'(i), i == 19);
        collect(20, 2000, 5, 50, dones);
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL bp_done_count: %0d, required 1", dones);
        end
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL bp_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    task automatic test_rx_en();
        int   dones, w;
        logic seen, ack_e;
        for (int i = 0; i < 6; i++) push_word(3, 16'h9100 + 16'(i), i == 5);
        w = 0;
        while (!(busy && Receive_Direction == 2'd3) && w < 200) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w >= 200) begin
            miscompares++;
            $display("FAIL rxen_grant_n: busy %b dir %0d, required 1/3", busy, Receive_Direction);
        end
        rx_en = 1'b0;
        ack_e = E_RX_ACK;
        push_word(0, 16'hE100, 1'b0);
        push_word(0, 16'hE101, 1'b1);
        collect(6, 800, -1, 0, dones);
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL rxen_n_done: %0d, required 1", dones);
        end
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (busy || M_AXIS_TVALID || E_RX_ACK !== ack_e) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL rxen_hold: activity %b while rx_en=0, required 0", seen);
        end
        rx_en = 1'b1;
        collect(2, 600, -1, 0, dones);
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL rxen_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        int dones, w;
        tready = 1'b0;
        for (int i = 0; i < 10; i++) push_link(0, 16'hD000 + 16'(i));
        w = 0;
        while (!M_AXIS_TVALID && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        link_clr = 1'b1;
        #1;
        vectors++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP, RECE_DONE, RECE_COUNT,
             Receive_Direction, busy, ack_vec} !== '0) begin
            miscompares++;
            $display("FAIL midreset_state: tvalid %b tlast %b tdata %h tkeep %b done %b count %0d dir %0d busy %b acks %b, required all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP, RECE_DONE, RECE_COUNT,
                     Receive_Direction, busy, ack_vec);
        end
        sb.delete();
        exp_count = 0;
        repeat (3) @(negedge clk);
        link_clr = 1'b0;
        rst_n    = 1'b1;
        tready   = 1'b1;
        @(negedge clk);
        push_word(0, 16'hE200, 1'b0);
        push_word(0, 16'hE201, 1'b1);
        push_word(1, 16'h5200, 1'b0);
        push_word(1, 16'h5201, 1'b1);
        collect(4, 800, -1, 0, dones);
        vectors++;
        if (RECE_COUNT !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL midreset_count: %0d, required %0d", RECE_COUNT, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_back_to_back();
        test_max_burst();
        test_backpressure();
        test_rx_en();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_beats: %0d expected beats never seen, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
